// File: rtl/unpacker.sv
// unpacker: latches a wide word on Sta and returns one element per ReqDat,
// highest-index element first, each ValDat exactly one clock after its request.
module unpacker #(
  parameter int NUM_DATA   = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [$clog2(NUM_DATA):0]        NumUnpacker,
  input  logic                             Sta,
  input  logic                             Bypass,
  input  logic [DATA_WIDTH*NUM_DATA-1:0]   DatUnpacker,
  input  logic                             ReqDat,
  output logic                             ValDat,
  output logic [DATA_WIDTH-1:0]            Dat,
  output logic                             Busy,
  output logic                             FnhUnpacker,
  output logic                             ErrReq
);
  localparam int IW = $clog2(NUM_DATA);
  localparam int CW = IW + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] word;
  logic [CW-1:0] nlat, cnt, nclamp;
  logic [IW-1:0] idx;
  logic start, zero, take, last;
  assign nclamp = (NumUnpacker > CW'(NUM_DATA)) ? CW'(NUM_DATA) : NumUnpacker;
  assign zero   = Bypass | (Sta & (NumUnpacker == '0));
  assign start  = Sta & ~Bypass & (NumUnpacker != '0);
  // a new Sta or Bypass pre-empts any request in the same cycle
  assign take   = (state == SEND) & ReqDat & ~Sta & ~Bypass;
  assign last   = take & (cnt == nlat - 1'b1);
  assign idx    = IW'(nlat - 1'b1 - cnt);
  assign Busy   = (state == SEND);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = zero ? IDLE : start ? SEND : last ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word        <= '0;
      nlat        <= '0;
      cnt         <= '0;
      ValDat      <= 1'b0;
      Dat         <= '0;
      FnhUnpacker <= 1'b0;
      ErrReq      <= 1'b0;
    end else begin
      word        <= start ? DatUnpacker : word;
      nlat        <= start ? nclamp : nlat;
      cnt         <= (start | zero | last) ? '0 : take ? cnt + 1'b1 : cnt;
      ValDat      <= take;
      Dat         <= take ? word[idx] : Dat;
      FnhUnpacker <= zero | last;
      ErrReq      <= start ? 1'b0 : ((state == IDLE) & ReqDat) ? 1'b1 : ErrReq;
    end
endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: randomized and directed checks of unpacker against a queue-based model.
module tb_unpacker;
  localparam int ND = 32;
  localparam int W  = 8;
  localparam int CW = 6;
  logic clk = 0, rst_n = 0;
  logic [CW-1:0] num = '0;
  logic sta = 0, byp = 0, req = 0;
  logic [ND*W-1:0] word = '0;
  logic val, fnh, busy, err;
  logic [W-1:0] dat;
  int vectors = 0, miscompares = 0;
  byte unsigned q[$];
  logic m_val = 0, m_fnh = 0, m_err = 0;
  logic [W-1:0] m_dat = '0;

  unpacker #(.NUM_DATA(ND), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .NumUnpacker(num), .Sta(sta), .Bypass(byp),
    .DatUnpacker(word), .ReqDat(req), .ValDat(val), .Dat(dat), .Busy(busy),
    .FnhUnpacker(fnh), .ErrReq(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] expv();
    return {m_val, m_dat, m_fnh, q.size() != 0, m_err};
  endfunction

  function automatic logic [ND*W-1:0] rand_word();
    logic [ND*W-1:0] w;
    for (int i = 0; i < ND*W/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [ND*W-1:0] ramp_word(input int base);
    logic [ND*W-1:0] w;
    for (int i = 0; i < ND; i++) w[i*W +: W] = W'(base + i);
    return w;
  endfunction

  // One clock with the given inputs; the model advances from the spec's rules:
  // a transfer is a queue of elements, top index first; SEND means queue non-empty.
  task automatic cyc(input logic s, input logic b, input logic r,
                     input logic [CW-1:0] n, input logic [ND*W-1:0] w);
    bit idle;
    int k;
    idle = (q.size() == 0);
    sta = s; byp = b; req = r; num = n; word = w;
    @(posedge clk); #1;
    m_val = 0; m_fnh = 0;
    if (r && idle && !(s && !b && n != 0)) m_err = 1;
    if (b) begin
      q.delete();
      m_fnh = 1;
    end else if (s) begin
      q.delete();
      if (n == 0) m_fnh = 1;
      else begin
        k = (n > ND) ? ND : int'(n);
        m_err = 0;
        for (int i = k - 1; i >= 0; i--) q.push_back(w[i*W +: W]);
      end
    end else if (r && !idle) begin
      m_val = 1;
      m_dat = q.pop_front();
      m_fnh = (q.size() == 0);
    end
    sta = 0; byp = 0; req = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({val, dat, fnh, busy, err} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset got %h exp %h", {val, dat, fnh, busy, err}, 12'h0);
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    logic [ND*W-1:0] w = ramp_word(1);
    for (int c = 0; c < 6; c++) begin
      if (c == 0) cyc(1, 0, 0, 4, w);
      else cyc(0, 0, c <= 4, 0, '0);
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL basic cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
    end
  endtask

  task automatic test_gaps();
    bit pat[6] = '{1, 0, 0, 1, 1, 0};
    int c = 0, nf = 0, nv = 0;
    cyc(1, 0, 0, 32, ramp_word(1));
    while ((q.size() != 0 || c < 3) && c < 400) begin
      cyc(0, 0, (c < 6) ? pat[c] : 1'($urandom_range(0, 1)), 0, '0);
      nf += fnh; nv += val;
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL gaps cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
      c++;
    end
    vectors++;
    if (nf !== 1 || nv !== 32) begin
      miscompares++;
      $display("FAIL gaps_counts fnh %0d val %0d exp 1 32 (cycles %0d)", nf, nv, c);
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) cyc(0, 1, 0, 5, rand_word());
      else if (c == 2) cyc(1, 0, 0, 0, rand_word());
      else cyc(0, 0, 0, 0, '0);
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL bypass cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
    end
  endtask

  task automatic test_abort();
    int nf = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) cyc(1, 0, 0, 8, ramp_word(1));
      else if (c == 4) cyc(1, 0, 1, 2, ramp_word(8'hA0));
      else cyc(0, 0, c < 8, 0, '0);
      nf += fnh;
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL abort cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
    end
    vectors++;
    if (nf !== 1) begin
      miscompares++;
      $display("FAIL abort_fnh got %0d exp 1", nf);
    end
  endtask

  task automatic test_idle_req_clamp();
    for (int c = 0; c < 38; c++) begin
      if (c == 3) cyc(1, 0, 0, 40, rand_word());
      else cyc(0, 0, c == 0 || c > 3, 0, '0);
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL clamp cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 16, rand_word());
    repeat (5) cyc(0, 0, 1, 0, '0);
    #2 rst_n = 0;
    #1;
    q.delete(); m_val = 0; m_dat = '0; m_fnh = 0; m_err = 0;
    vectors++;
    if ({val, dat, fnh, busy, err} !== expv()) begin
      miscompares++;
      $display("FAIL async_reset got %h exp %h", {val, dat, fnh, busy, err}, expv());
    end
    @(posedge clk); #1;
    vectors++;
    if ({val, dat, fnh, busy, err} !== expv()) begin
      miscompares++;
      $display("FAIL reset_hold got %h exp %h", {val, dat, fnh, busy, err}, expv());
    end
    rst_n = 1;
    for (int c = 0; c < 18; c++) begin
      if (c == 0) cyc(1, 0, 0, 16, rand_word());
      else cyc(0, 0, 1, 0, '0);
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL after_reset cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
          CW'($urandom_range(0, 63)), rand_word());
      vectors++;
      if ({val, dat, fnh, busy, err} !== expv()) begin
        miscompares++;
        $display("FAIL random cyc %0d got %h exp %h", c, {val, dat, fnh, busy, err}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bypass();
    test_abort();
    test_idle_req_clamp();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
